// File: rtl/intr_responder_if.sv
// Signal bundle between the interrupt responder and its controller/CPU environment.
// The master side drives requests and CPU status; the slave side is the responder.
interface intr_responder_if;
    logic        IRQ;
    logic [31:0] isr_addr;
    logic        error;
    logic        instr_boundary;
    logic [31:0] pc_next;
    logic        eret;
    logic        ie_we;
    logic        ie_wd;
    logic        err_clr;

    logic        IACK;
    logic        redirect_valid;
    logic [31:0] pc_redirect;
    logic [31:0] epc;
    logic        in_isr;
    logic        ie;
    logic        err_sticky;
    logic [15:0] int_count;

    modport master (
        output IRQ, isr_addr, error, instr_boundary, pc_next, eret,
               ie_we, ie_wd, err_clr,
        input  IACK, redirect_valid, pc_redirect, epc, in_isr, ie,
               err_sticky, int_count
    );

    modport slave (
        input  IRQ, isr_addr, error, instr_boundary, pc_next, eret,
               ie_we, ie_wd, err_clr,
        output IACK, redirect_valid, pc_redirect, epc, in_isr, ie,
               err_sticky, int_count
    );
endinterface

// File: rtl/intr_responder.sv
// Interrupt entry/return sequencer: accepts a request at an instruction boundary,
// redirects the CPU to the vector, and redirects back to the saved PC on eret.
module intr_responder (
    input  logic             clk,
    input  logic             rst,
    intr_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENTER   = 2'd1,
        S_SERVICE = 2'd2,
        S_EXIT    = 2'd3
    } state_e;

    state_e      state_q;
    logic        ie_q;
    logic        iack_q;
    logic        redirect_valid_q;
    logic [31:0] pc_redirect_q;
    logic [31:0] epc_q;
    logic        in_isr_q;
    logic        err_sticky_q;
    logic [15:0] int_count_q;
    logic [15:0] int_count_d;
    logic        accept;
    logic        err_set;

    assign accept      = (state_q == S_IDLE) && bus.IRQ && ie_q && bus.instr_boundary;
    assign err_set     = bus.error || (bus.eret && (state_q != S_SERVICE));
    assign int_count_d = (int_count_q == 16'hFFFF) ? int_count_q : int_count_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            ie_q             <= 1'b0;
            iack_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            pc_redirect_q    <= 32'd0;
            epc_q            <= 32'd0;
            in_isr_q         <= 1'b0;
            err_sticky_q     <= 1'b0;
            int_count_q      <= 16'd0;
        end else begin
            iack_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            pc_redirect_q    <= 32'd0;

            if (err_set) begin
                err_sticky_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_sticky_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    // The accept decision uses the old ie; a coincident write loses.
                    if (accept) begin
                        state_q          <= S_ENTER;
                        epc_q            <= bus.pc_next;
                        ie_q             <= 1'b0;
                        iack_q           <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        pc_redirect_q    <= bus.isr_addr;
                        int_count_q      <= int_count_d;
                        in_isr_q         <= 1'b1;
                    end else if (bus.ie_we) begin
                        ie_q <= bus.ie_wd;
                    end
                end
                S_ENTER: begin
                    state_q <= S_SERVICE;
                end
                S_SERVICE: begin
                    if (bus.ie_we) begin
                        ie_q <= bus.ie_wd;
                    end
                    if (bus.eret) begin
                        state_q          <= S_EXIT;
                        redirect_valid_q <= 1'b1;
                        pc_redirect_q    <= epc_q;
                        in_isr_q         <= 1'b0;
                    end
                end
                S_EXIT: begin
                    // Re-enabling here overrides any ie write made alongside eret.
                    ie_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.IACK           = iack_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.pc_redirect    = pc_redirect_q;
    assign bus.epc            = epc_q;
    assign bus.in_isr         = in_isr_q;
    assign bus.ie             = ie_q;
    assign bus.err_sticky     = err_sticky_q;
    assign bus.int_count      = int_count_q;

endmodule

// File: doc/intr_responder.md
INTR_RESPONDER -- requirements
Module: intr_responder

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port IRQ, input, 1 bit: interrupt request from the interrupt controller, level.
REQ-004 The block SHALL have the port isr_addr, input, 32 bits: vector from the controller, valid while IRQ=1.
REQ-005 The block SHALL have the port error, input, 1 bit: controller error flag.
REQ-006 The block SHALL have the port instr_boundary, input, 1 bit: the CPU may be redirected this cycle.
REQ-007 The block SHALL have the port pc_next, input, 32 bits: return address, valid when instr_boundary=1.
REQ-008 The block SHALL have the port eret, input, 1 bit: the CPU executes return-from-interrupt, one-cycle pulse.
REQ-009 The block SHALL have the ports ie_we (input, 1 bit) and ie_wd (input, 1 bit): software write of the global interrupt enable.
REQ-010 The block SHALL have the port err_clr, input, 1 bit: clears err_sticky.
REQ-011 The block SHALL have the port IACK, output, 1 bit: acknowledge to the controller, one-cycle pulse.
REQ-012 The block SHALL have the ports redirect_valid (output, 1 bit) and pc_redirect (output, 32 bits): PC override for the CPU.
REQ-013 The block SHALL have the ports epc (output, 32 bits) and in_isr (output, 1 bit): saved return address; handler active.
REQ-014 The block SHALL have the ports ie (output, 1 bit), err_sticky (output, 1 bit) and int_count (output, 16 bits): enable, error status, count of taken interrupts.

Function
REQ-015 The block SHALL implement states IDLE, ENTER, SERVICE and EXIT; all outputs SHALL be registered.
REQ-016 In IDLE, the block SHALL accept an interrupt on a cycle where IRQ=1, ie=1 and instr_boundary=1; otherwise it SHALL stay in IDLE.
REQ-017 On accept, the block SHALL latch epc<=pc_next and vector<=isr_addr, clear ie to 0, and go to ENTER.
REQ-018 In ENTER (exactly 1 cycle), IACK SHALL be 1, redirect_valid SHALL be 1, pc_redirect SHALL equal the latched vector, and int_count SHALL increment, saturating at 0xFFFF; the next state SHALL be SERVICE.
REQ-019 In SERVICE, in_isr SHALL be 1 and IRQ SHALL be ignored; if IRQ is still or again high it SHALL be serviced only after return.
REQ-020 In SERVICE, eret=1 SHALL move the block to EXIT.
REQ-021 In EXIT (exactly 1 cycle), redirect_valid SHALL be 1 and pc_redirect SHALL equal epc; ie SHALL be set to 1 and the next state SHALL be IDLE.
REQ-022 IACK SHALL be 1 only in ENTER; redirect_valid SHALL be 1 only in ENTER and EXIT; pc_redirect SHALL be 0 otherwise.
REQ-023 ie_we SHALL load ie<=ie_wd on the next edge in IDLE and SERVICE.
REQ-024 If ie_we coincides with an accept, the accept SHALL use the old ie and ie SHALL end at 0.
REQ-025 If ie_we coincides with eret, ie SHALL end at 1.
REQ-026 ie_we SHALL be ignored in ENTER and EXIT.
REQ-027 eret outside SERVICE SHALL be ignored for state and SHALL set err_sticky.
REQ-028 error=1 on any cycle SHALL set err_sticky.
REQ-029 err_clr SHALL clear err_sticky; a set condition on the same cycle SHALL win.
REQ-030 epc SHALL hold its value until the next accept.
REQ-031 IRQ dropping between accept and ENTER SHALL NOT abort the sequence; ENTER still occurs.

Reset
REQ-032 While rst=1 at an edge, the block SHALL go to IDLE with ie=0, IACK=0, redirect_valid=0, pc_redirect=0, epc=0, in_isr=0, err_sticky=0 and int_count=0.
REQ-033 Reset SHALL take priority over every other input, including mid-ENTER and mid-SERVICE, and no IACK SHALL be emitted after reset.

Verification
REQ-034 Bench scenario: ie=1, IRQ=1, isr_addr=0x0000000D, instr_boundary=1, pc_next=0x00400010 -> next cycle IACK=1, redirect_valid=1 and pc_redirect=0x0000000D for 1 cycle; epc=0x00400010, in_isr=1, ie=0, int_count=1.
REQ-035 Bench scenario: eret pulse in SERVICE -> next cycle redirect_valid=1 and pc_redirect=0x00400010; then IDLE, ie=1, in_isr=0.
REQ-036 Bench scenario: IRQ held high through service with isr_addr changed to 0x0000000B -> no second IACK until after EXIT; then a second ENTER with pc_redirect=0x0000000B and int_count=2.
REQ-037 Bench scenario: ie=0 with IRQ=1 for 20 cycles -> IACK stays 0; ie_we=1, ie_wd=1 -> accept within 2 cycles of instr_boundary=1.
REQ-038 Bench scenario: eret in IDLE -> err_sticky=1 with state unchanged; err_clr -> err_sticky=0; error pulse -> err_sticky=1.
REQ-039 Bench scenario: rst asserted during SERVICE -> all outputs at reset values next cycle; a pending IRQ is not taken until ie is written to 1.
